// File: rtl/softmax_backward_if.sv
// Job handshake and result bus between the softmax backward block and its user.
// Signal names follow the original module's port list.
interface softmax_backward_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SM_WIDTH    = 10
);
    logic                                  start;
    logic [NUM_CLASSES-1:0][SM_WIDTH-1:0]  dense_softmax;
    logic [3:0]                            label;
    logic                                  busy;
    logic                                  done;
    logic                                  delta_valid;
    logic [3:0]                            delta_idx;
    logic [SM_WIDTH:0]                     delta_data;
    logic [NUM_CLASSES-1:0][SM_WIDTH:0]    dense_delta;
    logic [3:0]                            pred;
    logic                                  correct;
    logic                                  label_err;

    modport master (
        output start, dense_softmax, label,
        input  busy, done, delta_valid, delta_idx, delta_data,
               dense_delta, pred, correct, label_err
    );

    modport slave (
        input  start, dense_softmax, label,
        output busy, done, delta_valid, delta_idx, delta_data,
               dense_delta, pred, correct, label_err
    );
endinterface

// File: rtl/softmax_backward.sv
// Output-layer error delta = softmax - onehot(label), streamed one class per cycle,
// with argmax prediction and correctness flag reported on the done pulse.
module softmax_backward #(
    parameter int NUM_CLASSES           = 10,
    parameter int SM_WIDTH              = 10,
    parameter int NUM_DECIMAL_IN_BINARY = 6
) (
    input logic               clk,
    input logic               rst_n,
    softmax_backward_if.slave bus
);
    localparam int DW = SM_WIDTH + 1;
    localparam logic [3:0]                 LAST_IDX = 4'(NUM_CLASSES - 1);
    localparam logic signed [DW-1:0]       ONE      = DW'(1 << NUM_DECIMAL_IN_BINARY);
    localparam logic signed [SM_WIDTH-1:0] MOST_NEG = {1'b1, {(SM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                              r_state;
    logic [NUM_CLASSES-1:0][SM_WIDTH-1:0] r_sm;
    logic [3:0]                          r_label;
    logic [3:0]                          r_idx;
    logic [3:0]                          r_best;
    logic signed [SM_WIDTH-1:0]          r_best_val;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_delta_valid;
    logic [3:0]                          r_delta_idx;
    logic [DW-1:0]                       r_delta_data;
    logic [NUM_CLASSES-1:0][DW-1:0]      r_dense_delta;
    logic [3:0]                          r_pred;
    logic                                r_correct;
    logic                                r_label_err;

    logic signed [SM_WIDTH-1:0] w_cur;
    logic signed [DW-1:0]       w_sext;
    logic signed [DW-1:0]       w_delta;
    logic                       w_label_err;

    // Full-width subtraction after sign extension: range fits DW bits, no saturation.
    always_comb begin
        w_cur       = r_sm[r_idx];
        w_sext      = {w_cur[SM_WIDTH-1], w_cur};
        w_delta     = w_sext - ((r_idx == r_label) ? ONE : '0);
        w_label_err = (r_label > LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sm          <= '0;
            r_label       <= '0;
            r_idx         <= '0;
            r_best        <= '0;
            r_best_val    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_delta_valid <= 1'b0;
            r_delta_idx   <= '0;
            r_delta_data  <= '0;
            r_dense_delta <= '0;
            r_pred        <= '0;
            r_correct     <= 1'b0;
            r_label_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done        <= 1'b0;
                    r_delta_valid <= 1'b0;
                    if (bus.start) begin
                        r_sm       <= bus.dense_softmax;
                        r_label    <= bus.label;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_best     <= '0;
                        r_best_val <= MOST_NEG;
                        r_state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_dense_delta[r_idx] <= w_delta;
                    r_delta_data         <= w_delta;
                    r_delta_idx          <= r_idx;
                    r_delta_valid        <= 1'b1;
                    r_idx                <= r_idx + 4'd1;
                    // Strict compare keeps the lowest index on ties.
                    if (w_cur > r_best_val) begin
                        r_best     <= r_idx;
                        r_best_val <= w_cur;
                    end
                    if (r_idx == LAST_IDX)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_delta_valid <= 1'b0;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_pred        <= r_best;
                    r_label_err   <= w_label_err;
                    r_correct     <= (r_best == r_label) && !w_label_err;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.delta_valid = r_delta_valid;
    assign bus.delta_idx   = r_delta_idx;
    assign bus.delta_data  = r_delta_data;
    assign bus.dense_delta = r_dense_delta;
    assign bus.pred        = r_pred;
    assign bus.correct     = r_correct;
    assign bus.label_err   = r_label_err;
endmodule

// File: tb/tb_softmax_backward.sv
// Self-checking bench for softmax_backward: directed cases plus random jobs
// compared against an arithmetic model of delta, argmax and flags.
module tb_softmax_backward;
    localparam int NC  = 10;
    localparam int SMW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    softmax_backward_if #(.NUM_CLASSES(NC), .SM_WIDTH(SMW)) bus ();

    softmax_backward #(
        .NUM_CLASSES(NC),
        .SM_WIDTH(SMW),
        .NUM_DECIMAL_IN_BINARY(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
        chk({tag, "_valid"}, int'(bus.delta_valid), 0);
        chk({tag, "_idx"},   int'(bus.delta_idx), 0);
        chk({tag, "_data"},  int'(bus.delta_data), 0);
        chk({tag, "_pred"},  int'(bus.pred), 0);
        chk({tag, "_corr"},  int'(bus.correct), 0);
        chk({tag, "_lerr"},  int'(bus.label_err), 0);
        for (int k = 0; k < NC; k++)
            chk($sformatf("%s_dd%0d", tag, k), int'(bus.dense_delta[k]), 0);
    endtask

    task automatic launch(input int sm[NC], input int lbl);
        @(negedge clk);
        for (int k = 0; k < NC; k++) bus.dense_softmax[k] = SMW'(sm[k]);
        bus.label = 4'(lbl);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Latched values must be used; scramble the live inputs.
        for (int k = 0; k < NC; k++) bus.dense_softmax[k] = SMW'($urandom);
        bus.label = 4'($urandom);
    endtask

    task automatic run_job(input string tag, input int sm[NC], input int lbl, input bit poke);
        int exp_d[NC];
        int best, bestv, err, corr;
        best = 0;
        bestv = -100000;
        for (int k = 0; k < NC; k++) begin
            exp_d[k] = sm[k] - ((k == lbl) ? 64 : 0);
            if (sm[k] > bestv) begin
                bestv = sm[k];
                best  = k;
            end
        end
        err  = (lbl >= NC) ? 1 : 0;
        corr = (best == lbl && err == 0) ? 1 : 0;

        launch(sm, lbl);
        chk({tag, "_busy_e0"}, int'(bus.busy), 1);
        for (int c = 1; c <= NC + 2; c++) begin
            @(posedge clk);
            #1;
            if (c <= NC) begin
                chk($sformatf("%s_valid%0d", tag, c), int'(bus.delta_valid), 1);
                chk($sformatf("%s_idx%0d", tag, c), int'(bus.delta_idx), c - 1);
                chk($sformatf("%s_data%0d", tag, c), int'($signed(bus.delta_data)), exp_d[c-1]);
                chk($sformatf("%s_done%0d", tag, c), int'(bus.done), 0);
                chk($sformatf("%s_busy%0d", tag, c), int'(bus.busy), 1);
                if (poke && c == 4) bus.start = 1'b1;
                if (c == 5) bus.start = 1'b0;
            end else if (c == NC + 1) begin
                chk({tag, "_done"},  int'(bus.done), 1);
                chk({tag, "_busyd"}, int'(bus.busy), 0);
                chk({tag, "_vald"},  int'(bus.delta_valid), 0);
                chk({tag, "_pred"},  int'(bus.pred), best);
                chk({tag, "_corr"},  int'(bus.correct), corr);
                chk({tag, "_lerr"},  int'(bus.label_err), err);
                for (int k = 0; k < NC; k++)
                    chk($sformatf("%s_dd%0d", tag, k), int'($signed(bus.dense_delta[k])), exp_d[k]);
            end else begin
                chk({tag, "_done_pulse"}, int'(bus.done), 0);
                chk({tag, "_busy_after"}, int'(bus.busy), 0);
                chk({tag, "_pred_hold"},  int'(bus.pred), best);
                chk({tag, "_dd9_hold"},   int'($signed(bus.dense_delta[NC-1])), exp_d[NC-1]);
            end
        end
    endtask

    int sm[NC];
    int lbl;

    initial begin
        bus.start = 1'b0;
        bus.label = '0;
        bus.dense_softmax = '0;
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // T1
        for (int k = 0; k < NC; k++) sm[k] = 0;
        sm[0] = 64;
        run_job("t1", sm, 0, 1'b0);
        // T2
        for (int k = 0; k < NC; k++) sm[k] = 0;
        sm[3] = 40; sm[7] = 24;
        run_job("t2", sm, 7, 1'b0);
        // T3: ties
        for (int k = 0; k < NC; k++) sm[k] = 6;
        run_job("t3", sm, 9, 1'b0);
        // T4: extremes
        for (int k = 0; k < NC; k++) sm[k] = 0;
        sm[5] = 511; sm[2] = -512;
        run_job("t4", sm, 2, 1'b0);
        // T5: bad label
        for (int k = 0; k < NC; k++) sm[k] = 0;
        sm[0] = 64;
        run_job("t5", sm, 12, 1'b0);
        // T6a: start pulsed mid-job
        for (int k = 0; k < NC; k++) sm[k] = k * 3 - 10;
        run_job("t6a", sm, 4, 1'b1);

        // T6b: reset mid-job
        for (int k = 0; k < NC; k++) sm[k] = 100 - k;
        launch(sm, 1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_nodone%0d", c), int'(bus.done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NC; k++) sm[k] = 0;
        sm[6] = 64;
        run_job("t6c", sm, 6, 1'b0);

        // Random jobs; narrow-range batches force ties
        for (int j = 0; j < 24; j++) begin
            for (int k = 0; k < NC; k++)
                sm[k] = (j % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023)) - 512;
            lbl = (j % 5 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            if (j % 4 == 1) begin
                // Make the label the argmax sometimes so correct=1 is exercised.
                sm[lbl % NC] = 511;
            end
            run_job($sformatf("rnd%0d", j), sm, lbl, j[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
